// File: rtl/coeff_feeder.sv
// -----------------------------------------------------------------------------
// coeff_feeder
//   Upstream sequencer for the coefficient processor. Buffers one polynomial of
//   N_COEFF coefficients, issues them to the processor one at a time with the
//   t/q latched at start, writes each result back in place, and exposes the
//   finished polynomial through a registered random-access read port.
//
//   Optional feature: define FEEDER_WATCHDOG_EN to build a WAIT-state watchdog
//   that aborts to DONE with err_o set after TIMEOUT cycles without a result.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   load_*            coefficient write path (valid/data/ready)
//   start_i, t_i, q_i begin processing, moduli latched at start
//   proc_*_o          request to processor (t, q, data, one-cycle valid)
//   proc_*_i          processor ready/data/done
//   rd_addr_i/rd_data_o  result read port, 1-cycle latency
//   busy_o            ISSUE or WAIT
//   poly_done_o       DONE
//   clear_i           DONE -> LOAD
//   err_o             watchdog fired (sticky until clear_i/rst)
// -----------------------------------------------------------------------------
module coeff_feeder #(
   parameter int W       = 32,
   parameter int N_COEFF = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_valid_i,
   input  logic [W-1:0]               load_data_i,
   output logic                       load_ready_o,
   input  logic                       start_i,
   input  logic [W-1:0]               t_i,
   input  logic [W-1:0]               q_i,
   output logic [W-1:0]               proc_t_o,
   output logic [W-1:0]               proc_q_o,
   output logic [W-1:0]               proc_data_o,
   output logic                       proc_valid_o,
   input  logic                       proc_ready_i,
   input  logic [W-1:0]               proc_data_i,
   input  logic                       proc_done_i,
   input  logic [$clog2(N_COEFF)-1:0] rd_addr_i,
   output logic [W-1:0]               rd_data_o,
   output logic                       busy_o,
   output logic                       poly_done_o,
   input  logic                       clear_i,
   output logic                       err_o
);

   localparam int AW = $clog2(N_COEFF);
   localparam logic [AW:0] FULL = (AW+1)'(N_COEFF);
   localparam logic [AW:0] LAST = (AW+1)'(N_COEFF - 1);

   typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   idx_q, idx_d;
   logic [W-1:0]  t_q, q_q;
   logic [W-1:0]  pdata_q, pdata_d;
   logic [W-1:0]  rd_data_q;
   logic [W-1:0]  mem [N_COEFF];

   logic load_fire, start_fire, issue_fire, wr_res, timeout;

   assign load_fire  = (state_q == S_LOAD) && load_valid_i && (count_q != FULL);
   // A write in the same cycle never coincides with an accepted start: start
   // needs the buffer already full, and a full buffer refuses writes.
   assign start_fire = (state_q == S_LOAD) && start_i && (count_q == FULL);
   assign issue_fire = (state_q == S_ISSUE) && proc_ready_i;
   assign wr_res     = (state_q == S_WAIT) && proc_done_i;

`ifdef FEEDER_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_q;
   logic          err_q;

   // wd_q counts completed WAIT cycles; the TIMEOUT-th one without a result aborts.
   assign timeout = (state_q == S_WAIT) && !proc_done_i && (wd_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (issue_fire)             wd_q <= '0;
         else if (state_q == S_WAIT) wd_q <= wd_q + 1'b1;
         if (timeout)                          err_q <= 1'b1;
         else if (state_q == S_DONE && clear_i) err_q <= 1'b0;
      end
   end
   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_LOAD;
         count_q   <= '0;
         idx_q     <= '0;
         t_q       <= '0;
         q_q       <= '0;
         pdata_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         pdata_q   <= pdata_d;
         rd_data_q <= mem[rd_addr_i];
         if (start_fire) begin
            t_q <= t_i;
            q_q <= q_i;
         end
      end
   end

   // Buffer is deliberately not cleared by reset; writes are blocked while in reset
   // so a late processor result after an abort cannot land.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_fire)   mem[count_q[AW-1:0]] <= load_data_i;
         else if (wr_res) mem[idx_q[AW-1:0]]   <= proc_data_i;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      pdata_d = pdata_q;
      unique case (state_q)
         S_LOAD: begin
            if (load_fire) count_d = count_q + 1'b1;
            if (start_fire) begin
               state_d = S_ISSUE;
               idx_d   = '0;
               pdata_d = mem[0];
            end
         end
         S_ISSUE: if (proc_ready_i) state_d = S_WAIT;
         S_WAIT: begin
            if (timeout) state_d = S_DONE;
            else if (proc_done_i) begin
               if (idx_q == LAST) state_d = S_DONE;
               else begin
                  state_d = S_ISSUE;
                  idx_d   = idx_q + 1'b1;
                  // Next coefficient is staged here so proc_data_o is valid on
                  // the first ISSUE cycle.
                  pdata_d = mem[idx_d[AW-1:0]];
               end
            end
         end
         S_DONE: begin
            if (clear_i) begin
               state_d = S_LOAD;
               count_d = '0;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // Outputs
   always_comb begin
      load_ready_o = (state_q == S_LOAD) && (count_q != FULL);
      proc_valid_o = issue_fire;
      busy_o       = (state_q == S_ISSUE) || (state_q == S_WAIT);
      poly_done_o  = (state_q == S_DONE);
   end

   assign proc_t_o    = t_q;
   assign proc_q_o    = q_q;
   assign proc_data_o = pdata_q;
   assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_coeff_feeder.sv
module tb_coeff_feeder;
   localparam int W  = 32;
   localparam int N  = 4;
   localparam int TO = 8;

   logic          clk = 0;
   logic          rst = 0;
   logic          load_valid_i = 0;
   logic [W-1:0]  load_data_i = 0;
   logic          load_ready_o;
   logic          start_i = 0;
   logic [W-1:0]  t_i = 0, q_i = 0;
   logic [W-1:0]  proc_t_o, proc_q_o, proc_data_o;
   logic          proc_valid_o;
   logic          proc_ready_i = 0;
   logic [W-1:0]  proc_data_i = 0;
   logic          proc_done_i = 0;
   logic [1:0]    rd_addr_i = 0;
   logic [W-1:0]  rd_data_o;
   logic          busy_o, poly_done_o, err_o;
   logic          clear_i = 0;

   coeff_feeder #(.W(W), .N_COEFF(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
      .start_i(start_i), .t_i(t_i), .q_i(q_i),
      .proc_t_o(proc_t_o), .proc_q_o(proc_q_o), .proc_data_o(proc_data_o),
      .proc_valid_o(proc_valid_o), .proc_ready_i(proc_ready_i),
      .proc_data_i(proc_data_i), .proc_done_i(proc_done_i),
      .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .busy_o(busy_o), .poly_done_o(poly_done_o),
      .clear_i(clear_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // ---------------- reference model (spec-level) ----------------
   // phase: 0 loading, 1 issuing, 2 awaiting result, 3 finished
   int          m_st = 0, m_cnt = 0, m_idx = 0, m_wd = 0;
   logic [W-1:0] m_mem [N];
   bit          m_vld [N];
   logic [W-1:0] m_t = 0, m_q = 0, m_rd = 0;
   bit          m_rd_ok = 0, m_err = 0, m_live = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_st <= 0; m_cnt <= 0; m_idx <= 0; m_t <= 0; m_q <= 0;
         m_err <= 0; m_rd <= 0; m_rd_ok <= 1; m_live <= 1;
      end else begin
         m_rd    <= m_mem[rd_addr_i];
         m_rd_ok <= m_vld[rd_addr_i];
         case (m_st)
            0: if (load_valid_i && m_cnt < N) begin
                  m_mem[m_cnt] <= load_data_i; m_vld[m_cnt] <= 1; m_cnt <= m_cnt + 1;
               end else if (start_i && m_cnt == N) begin
                  m_st <= 1; m_idx <= 0; m_t <= t_i; m_q <= q_i;
               end
            1: if (proc_ready_i) begin m_st <= 2; m_wd <= 0; end
            2: if (proc_done_i) begin
                  m_mem[m_idx] <= proc_data_i;
                  if (m_idx == N-1) m_st <= 3;
                  else begin m_idx <= m_idx + 1; m_st <= 1; end
               end else begin
`ifdef FEEDER_WATCHDOG_EN
                  if (m_wd + 1 == TO) begin m_err <= 1; m_st <= 3; end
                  else m_wd <= m_wd + 1;
`endif
               end
            default: if (clear_i) begin m_cnt <= 0; m_st <= 0; m_err <= 0; end
         endcase
      end
   end

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare();
      if (!m_live) return;
      chk("load_ready", 32'(load_ready_o), 32'(m_st == 0 && m_cnt < N));
      chk("proc_valid", 32'(proc_valid_o), 32'(m_st == 1 && proc_ready_i));
      chk("busy",       32'(busy_o),       32'(m_st == 1 || m_st == 2));
      chk("poly_done",  32'(poly_done_o),  32'(m_st == 3));
      chk("err",        32'(err_o),        32'(m_err));
      if (m_st == 1 || m_st == 2) begin
         chk("proc_data", proc_data_o, m_mem[m_idx]);
         chk("proc_t", proc_t_o, m_t);
         chk("proc_q", proc_q_o, m_q);
      end
      if (m_rd_ok) chk("rd_data", rd_data_o, m_rd);
   endtask

   // ---------------- processor stand-in ----------------
   function automatic logic [W-1:0] pm(input logic [W-1:0] c, t, q);
      logic [63:0] p;
      p = {32'b0, c} * {32'b0, t};
      if (q == 0) return '0;
      return W'((p / {32'b0, q}) % {32'b0, q});
   endfunction

   int   pulses = 0, lat = 0, hang_at = 0;
   bit   pend = 0, hung = 0, late_done = 0, force_nready = 0, force_ready = 0, rd_hold = 0;
   logic [W-1:0] res = 0, pd_s, pt_s, pq_s;
   bit   pv_s;

   task automatic step();
      @(negedge clk);
      compare();
      pv_s = proc_valid_o; pd_s = proc_data_o; pt_s = proc_t_o; pq_s = proc_q_o;
      @(posedge clk); #1;
      proc_done_i = 0;
      proc_data_i = $urandom;
      if (pv_s) begin
         pulses++; pend = 1; lat = $urandom_range(0, 3);
         res  = pm(pd_s, pt_s, pq_s);
         hung = (hang_at != 0) && (pulses >= hang_at);
      end
      if (late_done) begin
         proc_done_i = 1; proc_data_i = 32'hDEAD; late_done = 0;
      end else if (pend && !hung) begin
         if (lat == 0) begin proc_done_i = 1; proc_data_i = res; pend = 0; end
         else lat--;
      end
      proc_ready_i = force_nready ? 1'b0 : force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!rd_hold) rd_addr_i = 2'($urandom_range(0, N-1));
   endtask

   task automatic load(input logic [W-1:0] v);
      load_valid_i = 1; load_data_i = v; step(); load_valid_i = 0;
   endtask

   task automatic start(input logic [W-1:0] t, input logic [W-1:0] q);
      start_i = 1; t_i = t; q_i = q; step(); start_i = 0;
      t_i = $urandom; q_i = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && !poly_done_o; i++) step();
      chk("done_reached", 32'(poly_done_o), 32'd1);
   endtask

   task automatic clear();
      clear_i = 1; step(); clear_i = 0;
      pend = 0; hung = 0; hang_at = 0;
   endtask

   task automatic rd_check(input int a, input logic [W-1:0] exp);
      rd_hold = 1; rd_addr_i = 2'(a); step();
      chk($sformatf("rd_lit[%0d]", a), rd_data_o, exp);
      rd_hold = 0;
   endtask

   logic [W-1:0] v [6];

   initial begin
      // reset
      rst = 1; step(); step();
      chk("rst_load_ready", 32'(load_ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_poly_done", 32'(poly_done_o), 32'd0);
      chk("rst_proc_valid", 32'(proc_valid_o), 32'd0);
      chk("rst_proc_data", proc_data_o, 32'd0);
      chk("rst_proc_t", proc_t_o, 32'd0);
      chk("rst_rd_data", rd_data_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      rst = 0; step();

      // basic flow
      load(32'h3); load(32'h10); load(32'h7); load(32'h1);
      pulses = 0;
      start(32'h15, 32'h7);
      wait_done();
      chk("basic_pulses", 32'(pulses), 32'd4);
      rd_check(0, 32'h2); rd_check(1, 32'h6); rd_check(2, 32'h0); rd_check(3, 32'h3);
      clear();

      // overfill
      for (int i = 0; i < 6; i++) begin
         v[i] = $urandom;
         load(v[i]);
         if (i == 3) chk("ovf_ready_after_4", 32'(load_ready_o), 32'd0);
      end
      for (int i = 0; i < 4; i++) rd_check(i, v[i]);
      pulses = 0;
      start($urandom, $urandom_range(1, 1000));
      wait_done();
      chk("ovf_pulses", 32'(pulses), 32'd4);
      clear();

      // early start, then write+start together at count==N-1
      pulses = 0;
      load($urandom); load($urandom);
      start(32'h5, 32'h3); step();
      chk("early_busy", 32'(busy_o), 32'd0);
      chk("early_pulses", 32'(pulses), 32'd0);
      load($urandom);
      load_valid_i = 1; load_data_i = $urandom; start_i = 1; step();
      load_valid_i = 0; start_i = 0;
      chk("wr_start_busy", 32'(busy_o), 32'd0);
      chk("wr_start_ready", 32'(load_ready_o), 32'd0);
      start($urandom, $urandom_range(1, 50));
      wait_done();
      chk("early_pulses_run", 32'(pulses), 32'd4);
      clear();

      // backpressure
      for (int i = 0; i < 4; i++) load($urandom);
      force_nready = 1; pulses = 0;
      start($urandom, $urandom_range(1, 99));
      for (int i = 0; i < 5; i++) step();
      chk("bp_no_pulse", 32'(pulses), 32'd0);
      chk("bp_busy", 32'(busy_o), 32'd1);
      force_nready = 0; force_ready = 1;
      step(); step();
      chk("bp_one_pulse", 32'(pulses), 32'd1);
      force_ready = 0;
      wait_done();
      clear();

      // reset in WAIT at idx 1, late done must not write
      for (int i = 0; i < 4; i++) begin v[i] = $urandom; load(v[i]); end
      pulses = 0; hang_at = 2;
      start($urandom, $urandom_range(1, 99));
      for (int i = 0; i < 300 && pulses < 2; i++) step();
      chk("rmo_second_pulse", 32'(pulses), 32'd2);
      step(); step();
      rst = 1; step(); rst = 0;
      pend = 0; hung = 0; hang_at = 0; late_done = 1;
      step(); step();
      chk("rmo_busy", 32'(busy_o), 32'd0);
      chk("rmo_state_load", 32'(load_ready_o), 32'd1);
      chk("rmo_poly_done", 32'(poly_done_o), 32'd0);
      rd_check(1, v[1]);

      // random polynomials; DONE ignores load/start
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) load($urandom);
         start($urandom, $urandom_range(1, 32'hFFFF));
         wait_done();
         load_valid_i = 1; load_data_i = $urandom; start_i = 1; step();
         load_valid_i = 0; start_i = 0;
         chk("done_hold", 32'(poly_done_o), 32'd1);
         for (int i = 0; i < 4; i++) step();
         clear();
      end

`ifdef FEEDER_WATCHDOG_EN
      for (int i = 0; i < 4; i++) load($urandom);
      pulses = 0; hang_at = 1;
      start($urandom, $urandom_range(1, 99));
      for (int i = 0; i < 300 && pulses < 1; i++) step();
      for (int i = 0; i < 7; i++) step();
      chk("wd_not_yet", 32'(poly_done_o), 32'd0);
      step();
      chk("wd_done", 32'(poly_done_o), 32'd1);
      chk("wd_err", 32'(err_o), 32'd1);
      clear();
      chk("wd_err_cleared", 32'(err_o), 32'd0);
`endif
      step(); step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/coeff_feeder.md
Name: coeff_feeder

Overview:
- Upstream sequencer for the coefficient processor.
- Buffers one polynomial of N_COEFF coefficients, then drives them into the processor one at a time (single outstanding request) with the latched t/q.
- Captures each processor result in place; the finished polynomial is read back through a random-access port.
- Sits between the host/DMA load path and the processor.

Parameters:
- W, 32: coefficient, t and q width; equals BIT_WIDTH from the HE headers.
- N_COEFF, 16: coefficients per polynomial; power of two, ≥2.
- TIMEOUT, 1024: watchdog limit in cycles; used only with FEEDER_WATCHDOG_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_valid_i  in  1  coefficient write strobe.
- load_data_i  in  W  coefficient to store.
- load_ready_o  out  1  buffer accepting writes.
- start_i  in  1  begin processing (pulse).
- t_i  in  W  plaintext modulus, latched at start.
- q_i  in  W  ciphertext modulus, latched at start.
- proc_t_o  out  W  t to processor.
- proc_q_o  out  W  q to processor.
- proc_data_o  out  W  coefficient to processor.
- proc_valid_o  out  1  one-cycle request pulse.
- proc_ready_i  in  1  processor ready_o.
- proc_data_i  in  W  processor data_o.
- proc_done_i  in  1  processor done_o.
- rd_addr_i  in  log2(N_COEFF)  result read address.
- rd_data_o  out  W  result read data.
- busy_o  out  1  state is ISSUE or WAIT.
- poly_done_o  out  1  state is DONE.
- clear_i  in  1  return from DONE to LOAD.
- err_o  out  1  watchdog fired (sticky until clear_i/rst).

Behaviour:
- States: LOAD (reset state), ISSUE, WAIT, DONE. Registers: count, idx (log2(N_COEFF)+1 bits), t_r, q_r.
- Reset values (next edge with rst=1): state LOAD, count=0, idx=0, all outputs 0 except load_ready_o=1. Buffer contents are not cleared. Reset mid-operation aborts immediately and ignores any later proc_done_i.
- LOAD:
  - load_ready_o = (count<N_COEFF).
  - Write occurs on load_valid_i && load_ready_o: mem[count] <= load_data_i, count++.
  - When count==N_COEFF, writes are refused (load_ready_o=0) and the data is dropped.
  - start_i is accepted only when count==N_COEFF: latch t_r/q_r, idx=0, go to ISSUE. start_i with count<N_COEFF is ignored.
  - Write and start in the same cycle at count==N_COEFF-1: the write is taken and start is ignored.
- ISSUE:
  - proc_data_o=mem[idx], proc_t_o=t_r, proc_q_o=q_r, all registered.
  - proc_valid_o is asserted for exactly one cycle, on the first cycle with proc_ready_i=1; then go to WAIT.
  - proc_done_i is ignored in ISSUE.
- WAIT:
  - proc_valid_o=0. proc_data_o, proc_t_o and proc_q_o are held stable.
  - On proc_done_i: mem[idx] <= proc_data_i. If idx==N_COEFF-1 go to DONE, else idx++ and go to ISSUE.
  - Minimum of 2 cycles per coefficient beyond processor latency.
- DONE:
  - poly_done_o=1 (level).
  - clear_i: count=0, go to LOAD.
  - start_i and load_valid_i are ignored.
- Read port: rd_data_o = mem[rd_addr_i] registered with 1-cycle latency, valid in any state. Reads during ISSUE/WAIT return a mix of old and new data.
- start_i and clear_i are ignored outside their stated states.
- Arithmetic: none on data; the block only stores and forwards W-bit values.

Optional Feature:
- Macro: FEEDER_WATCHDOG_EN.
- With the macro:
  - A cycle counter resets on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without proc_done_i: err_o=1 (sticky), go to DONE, and the mem[idx] write is skipped.
  - err_o clears on clear_i or rst.
- Without the macro: no counter is built, err_o is tied 0, and WAIT holds indefinitely.

Test Plan:
- Basic flow: rst, N_COEFF=4, load 0x3,0x10,0x7,0x1, start with t=0x15, q=0x7. The bench processor model computes ((c*t)/q)%q. Required: exactly 4 proc_valid_o pulses, then poly_done_o=1, and reads of addr 0..3 return 0x2,0x6,0x0,0x3.
- Overfill: load 6 values with N_COEFF=4 → load_ready_o=0 after the 4th; addresses 0..3 hold the first 4 values.
- Early start: start_i after 2 loads → state stays LOAD, no proc_valid_o. Then load 2 more and start → processing runs.
- Backpressure: proc_ready_i low for 5 cycles in ISSUE → no pulse; a single pulse follows the cycle ready rises; proc_data_o stays stable through WAIT.
- Reset mid-op: rst in WAIT at idx=1, followed by a late proc_done_i → state LOAD, count=0, busy_o=0, no write.
- Watchdog (FEEDER_WATCHDOG_EN, TIMEOUT=8): processor never asserts done → err_o=1 and poly_done_o=1 eight WAIT cycles after the first pulse; clear_i returns err_o to 0.
